mem_rd_arbiter: RTL and testbench
=================================

# mem_rd_arbiter

Shares the single external read channel between the instruction-cache refill path and the data-cache refill path. It accepts line or single-word read requests from both caches and arbitrates round-robin on conflict. It drives one AXI-style address/data read transaction at a time and returns each data beat, tagged with its beat index, to the owning cache. It sits between the icache/dcache miss handlers and the bus bridge.

## Interface
- `BEAT_NUM`, default 4: beats (32-bit words) per cache-line refill; power of two, 2..16.
- `clk` in 1: clock, all state updates on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ic_rd_req` in 1: icache read request; sampled only in IDLE.
- `ic_rd_addr` in 32: icache physical address.
- `ic_rd_line` in 1: 1 = line burst of BEAT_NUM beats, 0 = single uncached word.
- `ic_rd_gnt` out 1: one-cycle pulse when the icache request's address is accepted by the bus.
- `ic_rd_valid` out 1: data beat for icache this cycle.
- `ic_rd_last` out 1: final beat for icache.
- `ic_rd_idx` out 4: beat index of the current icache beat.
- `dc_rd_req`, `dc_rd_addr`, `dc_rd_line`, `dc_rd_gnt`, `dc_rd_valid`, `dc_rd_last`, `dc_rd_idx`: same as the ic_* ports, for dcache.
- `rd_data` out 32: beat data, shared by both requesters and qualified by *_rd_valid.
- `arvalid` out 1, `arready` in 1: address handshake.
- `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2: address attributes.
- `rvalid` in 1, `rready` out 1, `rdata` in 32, `rlast` in 1: data channel.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the requester not in `last_owner`.
  - `last_owner` resets to IC, so the first conflict after reset goes to dcache.
  - On a grant: latch owner, address, and line flag, then go to ADDR.
- Latched address:
  - Line request: `addr & ~(BEAT_NUM*4-1)`.
  - Single request: address unchanged.
- ADDR:
  - `arvalid`=1. araddr/arlen/arsize/arburst come from registers and are stable until `arready`.
  - `arlen` = BEAT_NUM-1 for a line, 0 for a single word.
  - `arsize`=3'b010, `arburst`=2'b01.
  - On `arready`: pulse the owner's `*_rd_gnt` in the same cycle, clear the beat counter, set `last_owner`=owner, go to DATA.
- DATA:
  - `rready`=1.
  - Each `rvalid` cycle: raise the owner's `*_rd_valid`, drive `rd_data`=`rdata`, drive `*_rd_idx`=beat counter, drive `*_rd_last`=`rlast`. Increment the counter (4-bit, wraps).
  - On `rvalid & rlast`: go to IDLE.
- Requester rules:
  - A requester keeps req/addr/line stable until its gnt.
  - Dropping req while in IDLE (before it is latched) withdraws it.
  - Once latched, a transaction always completes; there is no cancel. A requester that was flushed must still absorb its beats.
- The non-owner's valid, last, and gnt are always 0.
- Beat count mismatch: `rlast` alone terminates the transaction. If `rlast` arrives while the counter ≠ expected (BEAT_NUM-1 for a line, 0 for a single word), the beat is still delivered. This mismatch is a bus protocol violation and is a verification assertion only.

## Timing
- Reset values:
  - State = IDLE, `last_owner`=IC.
  - All gnt/valid/last = 0, idx = 0.
  - `arvalid`=0, `araddr`=0, `arlen`=0, `arsize`=0, `arburst`=0, `rready`=0, `rd_data`=0.
- Async reset mid-transaction returns to IDLE immediately. The bus bridge is reset by the same `rst_n`.
- Request latency:
  - A request seen in IDLE at cycle t gives `arvalid`=1 at t+1.
  - If `arready`=1 at t+1, gnt pulses at t+1 and DATA starts at t+2.
- Beat path: `rvalid` → `*_rd_valid` is combinational, zero cycles. `rd_data` is combinational from `rdata` while in DATA, and 0 otherwise.
- Back-to-back: `rlast` at cycle n → IDLE at n+1 (arbitration) → ADDR at n+2. Minimum turnaround is 2 cycles.
- A request that arrives while the block is busy waits in IDLE for the next arbitration. Round-robin bounds the wait to one competing transaction.

## Test plan
- Icache line only, `ic_rd_addr`=0x1C00_0014, `arready`=1 at once → `araddr`=0x1C00_0010, `arlen`=3, gnt at cycle 1. Four beats give `ic_rd_idx` 0,1,2,3 with `ic_rd_last` on idx 3. The dcache outputs stay 0.
- Both requests in the cycle after reset → dcache is served first. Icache is served next, and `arvalid` rises 2 cycles after dcache's `rlast`.
- Dcache single word, `dc_rd_line`=0, `dc_rd_addr`=0xBFD0_0004 → `araddr`=0xBFD0_0004, `arlen`=0. One beat with `dc_rd_last`=1, `dc_rd_idx`=0.
- `arready` held low for 5 cycles with beats inserting `rvalid` gaps → araddr/arlen are stable throughout and gnt pulses exactly once. Idx advances only on `rvalid` cycles.
- Assert `rst_n`=0 during beat 2 of a line → all outputs reach their reset values asynchronously. After release, a new icache request is arbitrated normally.
- Icache withdraws its req in IDLE in the same cycle dcache requests → dcache is granted and no icache transaction is issued.

Source files
------------

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter that shares one AXI-style read channel between the
// icache and dcache refill paths, one transaction at a time.
module mem_rd_arbiter #(
    parameter int unsigned BEAT_NUM = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ic_rd_req_i,
    input  logic [31:0] ic_rd_addr_i,
    input  logic        ic_rd_line_i,
    output logic        ic_rd_gnt_o,
    output logic        ic_rd_valid_o,
    output logic        ic_rd_last_o,
    output logic [3:0]  ic_rd_idx_o,

    input  logic        dc_rd_req_i,
    input  logic [31:0] dc_rd_addr_i,
    input  logic        dc_rd_line_i,
    output logic        dc_rd_gnt_o,
    output logic        dc_rd_valid_o,
    output logic        dc_rd_last_o,
    output logic [3:0]  dc_rd_idx_o,

    output logic [31:0] rd_data_o,

    output logic        arvalid_o,
    input  logic        arready_i,
    output logic [31:0] araddr_o,
    output logic [7:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,

    input  logic        rvalid_i,
    output logic        rready_o,
    input  logic [31:0] rdata_i,
    input  logic        rlast_i
);

    localparam int unsigned LINE_BYTES = BEAT_NUM * 4;
    localparam logic [31:0] LINE_MASK  = ~32'(LINE_BYTES - 1);
    localparam logic [7:0]  LINE_LEN   = 8'(BEAT_NUM - 1);
    localparam logic [3:0]  LINE_LAST  = 4'(BEAT_NUM - 1);
    localparam logic        OWN_IC     = 1'b0;
    localparam logic        OWN_DC     = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic        line_q, line_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [1:0]  arburst_q, arburst_d;
    logic [3:0]  beat_q, beat_d;

    logic        pick_dc;
    logic [31:0] sel_addr;

    // State and transaction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IC;
            last_owner_q <= OWN_IC;
            line_q       <= 1'b0;
            araddr_q     <= 32'd0;
            arlen_q      <= 8'd0;
            arsize_q     <= 3'd0;
            arburst_q    <= 2'd0;
            beat_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            line_q       <= line_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
            arburst_q    <= arburst_d;
            beat_q       <= beat_d;
        end
    end

    // Arbitration and next-state logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        line_d       = line_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arsize_d     = arsize_q;
        arburst_d    = arburst_q;
        beat_d       = beat_q;
        pick_dc      = 1'b0;
        sel_addr     = 32'd0;

        case (state_q)
            IDLE: begin
                if (ic_rd_req_i || dc_rd_req_i) begin
                    // On conflict the requester that did not own the last transaction wins
                    pick_dc   = dc_rd_req_i && (!ic_rd_req_i || (last_owner_q == OWN_IC));
                    owner_d   = pick_dc ? OWN_DC : OWN_IC;
                    line_d    = pick_dc ? dc_rd_line_i : ic_rd_line_i;
                    sel_addr  = pick_dc ? dc_rd_addr_i : ic_rd_addr_i;
                    araddr_d  = line_d ? (sel_addr & LINE_MASK) : sel_addr;
                    arlen_d   = line_d ? LINE_LEN : 8'd0;
                    arsize_d  = 3'b010;
                    arburst_d = 2'b01;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (arready_i) begin
                    beat_d       = 4'd0;
                    last_owner_d = owner_q;
                    state_d      = DATA;
                end
            end
            DATA: begin
                if (rvalid_i) begin
                    beat_d = beat_q + 4'd1;
                    if (rlast_i) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic in_addr_c;
    logic in_data_c;
    logic beat_c;

    assign in_addr_c = (state_q == ADDR);
    assign in_data_c = (state_q == DATA);
    assign beat_c    = in_data_c && rvalid_i;

    assign arvalid_o = in_addr_c;
    assign araddr_o  = araddr_q;
    assign arlen_o   = arlen_q;
    assign arsize_o  = arsize_q;
    assign arburst_o = arburst_q;
    assign rready_o  = in_data_c;
    assign rd_data_o = in_data_c ? rdata_i : 32'd0;

    // Beat return is zero-latency from the bus to the owning cache
    assign ic_rd_gnt_o   = in_addr_c && arready_i && (owner_q == OWN_IC);
    assign ic_rd_valid_o = beat_c && (owner_q == OWN_IC);
    assign ic_rd_last_o  = beat_c && rlast_i && (owner_q == OWN_IC);
    assign ic_rd_idx_o   = (in_data_c && (owner_q == OWN_IC)) ? beat_q : 4'd0;

    assign dc_rd_gnt_o   = in_addr_c && arready_i && (owner_q == OWN_DC);
    assign dc_rd_valid_o = beat_c && (owner_q == OWN_DC);
    assign dc_rd_last_o  = beat_c && rlast_i && (owner_q == OWN_DC);
    assign dc_rd_idx_o   = (in_data_c && (owner_q == OWN_DC)) ? beat_q : 4'd0;

    // A final beat arriving at the wrong count is a bus protocol violation
    always_ff @(posedge clk) begin
        if (rst_n && in_data_c && rvalid_i && rlast_i) begin
            assert (beat_q == (line_q ? LINE_LAST : 4'd0))
            else $error("mem_rd_arbiter: rlast on beat %0d", beat_q);
        end
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: drives the cache and bus sides by hand
// and compares every output against hand-computed values.
module tb_mem_rd_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ic_req, ic_line, dc_req, dc_line;
    logic [31:0] ic_addr, dc_addr;
    logic        ic_gnt, ic_valid, ic_last, dc_gnt, dc_valid, dc_last;
    logic [3:0]  ic_idx, dc_idx;
    logic [31:0] rd_data;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_rd_arbiter #(.BEAT_NUM(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ic_rd_req_i  (ic_req),
        .ic_rd_addr_i (ic_addr),
        .ic_rd_line_i (ic_line),
        .ic_rd_gnt_o  (ic_gnt),
        .ic_rd_valid_o(ic_valid),
        .ic_rd_last_o (ic_last),
        .ic_rd_idx_o  (ic_idx),
        .dc_rd_req_i  (dc_req),
        .dc_rd_addr_i (dc_addr),
        .dc_rd_line_i (dc_line),
        .dc_rd_gnt_o  (dc_gnt),
        .dc_rd_valid_o(dc_valid),
        .dc_rd_last_o (dc_last),
        .dc_rd_idx_o  (dc_idx),
        .rd_data_o    (rd_data),
        .arvalid_o    (arvalid),
        .arready_i    (arready),
        .araddr_o     (araddr),
        .arlen_o      (arlen),
        .arsize_o     (arsize),
        .arburst_o    (arburst),
        .rvalid_i     (rvalid),
        .rready_o     (rready),
        .rdata_i      (rdata),
        .rlast_i      (rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, " arvalid"}, 32'(arvalid), 32'd0);
        chk({tag, " araddr"},  araddr, 32'd0);
        chk({tag, " arlen"},   32'(arlen), 32'd0);
        chk({tag, " arsize"},  32'(arsize), 32'd0);
        chk({tag, " arburst"}, 32'(arburst), 32'd0);
        chk({tag, " rready"},  32'(rready), 32'd0);
        chk({tag, " rd_data"}, rd_data, 32'd0);
        chk({tag, " gnt/val/last"},
            32'({ic_gnt, ic_valid, ic_last, dc_gnt, dc_valid, dc_last}), 32'd0);
        chk({tag, " idx"}, 32'({ic_idx, dc_idx}), 32'd0);
    endtask

    // Called in the ADDR cycle with arready already high
    task automatic addr_phase(input string tag, input logic to_dc,
                              input logic [31:0] exp_addr, input logic [7:0] exp_len);
        #1;
        chk({tag, " arvalid"}, 32'(arvalid), 32'd1);
        chk({tag, " araddr"},  araddr, exp_addr);
        chk({tag, " arlen"},   32'(arlen), 32'(exp_len));
        chk({tag, " arsize/burst"}, 32'({arsize, arburst}), 32'b01001);
        chk({tag, " ic_gnt"},  32'(ic_gnt), 32'(!to_dc));
        chk({tag, " dc_gnt"},  32'(dc_gnt), 32'(to_dc));
        tick();
        if (to_dc) dc_req = 1'b0; else ic_req = 1'b0;
        arready = 1'b0;
    endtask

    task automatic beat(input string tag, input logic to_dc, input logic [3:0] idx,
                        input logic last, input logic [31:0] data);
        rvalid = 1'b1;
        rdata  = data;
        rlast  = last;
        #1;
        chk({tag, " rready"},  32'(rready), 32'd1);
        chk({tag, " valid"},   32'({ic_valid, dc_valid}), to_dc ? 32'b01 : 32'b10);
        chk({tag, " last"},    32'({ic_last, dc_last}), last ? (to_dc ? 32'b01 : 32'b10) : 32'd0);
        chk({tag, " idx"},     32'(to_dc ? dc_idx : ic_idx), 32'(idx));
        chk({tag, " rd_data"}, rd_data, data);
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rdata  = 32'd0;
    endtask

    initial begin
        int gnt_seen;
        int e;
        int pat [7] = '{1, 0, 1, 0, 0, 1, 1};

        rst_n = 1'b0;
        ic_req = 1'b0; ic_addr = 32'd0; ic_line = 1'b0;
        dc_req = 1'b0; dc_addr = 32'd0; dc_line = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
        tick();
        tick();
        reset_chk("reset");

        // Icache line alone, arready immediately
        rst_n = 1'b1;
        ic_req = 1'b1; ic_addr = 32'h1C00_0014; ic_line = 1'b1; arready = 1'b1;
        #1;
        chk("t1 idle arvalid", 32'(arvalid), 32'd0);
        tick();
        addr_phase("t1", 1'b0, 32'h1C00_0010, 8'd3);
        for (int b = 0; b < 4; b++) begin
            beat("t1 beat", 1'b0, 4'(b), b == 3, 32'hA000_0000 + 32'(b));
        end
        #1;
        chk("t1 idle after", 32'({rready, ic_valid, dc_valid, arvalid}), 32'd0);
        chk("t1 rd_data idle", rd_data, 32'd0);

        // Conflict right after reset: dcache first, then icache with 2-cycle turnaround
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ic_req = 1'b1; ic_addr = 32'h1C00_0040; ic_line = 1'b1;
        dc_req = 1'b1; dc_addr = 32'h8000_0128; dc_line = 1'b1;
        arready = 1'b1;
        tick();
        addr_phase("t2 dc", 1'b1, 32'h8000_0120, 8'd3);
        for (int b = 0; b < 4; b++) begin
            beat("t2 dc beat", 1'b1, 4'(b), b == 3, 32'hD000_0000 + 32'(b));
        end
        arready = 1'b1;
        #1;
        chk("t2 turnaround n+1 arvalid", 32'(arvalid), 32'd0);
        tick();
        addr_phase("t2 ic", 1'b0, 32'h1C00_0040, 8'd3);
        for (int b = 0; b < 4; b++) begin
            beat("t2 ic beat", 1'b0, 4'(b), b == 3, 32'hC000_0000 + 32'(b));
        end

        // Dcache single uncached word
        dc_req = 1'b1; dc_addr = 32'hBFD0_0004; dc_line = 1'b0; arready = 1'b1;
        tick();
        addr_phase("t3", 1'b1, 32'hBFD0_0004, 8'd0);
        beat("t3 beat", 1'b1, 4'd0, 1'b1, 32'h1234_5678);

        // arready stalled 5 cycles, then beats with rvalid gaps
        ic_req = 1'b1; ic_addr = 32'h0000_1238; ic_line = 1'b1; arready = 1'b0;
        tick();
        gnt_seen = 0;
        for (int c = 1; c <= 6; c++) begin
            arready = (c == 6);
            #1;
            chk("t4 stall arvalid", 32'(arvalid), 32'd1);
            chk("t4 stall araddr", araddr, 32'h0000_1230);
            chk("t4 stall arlen", 32'(arlen), 32'd3);
            chk("t4 stall gnt", 32'(ic_gnt), 32'(c == 6));
            gnt_seen += int'(ic_gnt);
            tick();
        end
        ic_req = 1'b0;
        arready = 1'b0;
        e = 0;
        for (int k = 0; k < 7; k++) begin
            if (pat[k] == 1) begin
                beat("t4 beat", 1'b0, 4'(e), e == 3, 32'h5500_0000 + 32'(e));
                e++;
            end else begin
                #1;
                gnt_seen += int'(ic_gnt);
                chk("t4 gap valid", 32'(ic_valid), 32'd0);
                chk("t4 gap idx", 32'(ic_idx), 32'(e));
                tick();
            end
        end
        chk("t4 gnt count", 32'(gnt_seen), 32'd1);

        // Async reset during beat 2 of a line
        ic_req = 1'b1; ic_addr = 32'h2000_0000; ic_line = 1'b1; arready = 1'b1;
        tick();
        addr_phase("t5", 1'b0, 32'h2000_0000, 8'd3);
        beat("t5 beat", 1'b0, 4'd0, 1'b0, 32'h0000_0A00);
        beat("t5 beat", 1'b0, 4'd1, 1'b0, 32'h0000_0A01);
        rvalid = 1'b1; rdata = 32'h0000_0A02;
        #1;
        chk("t5 beat2 valid", 32'(ic_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        reset_chk("t5 async");
        tick();
        rvalid = 1'b0; rdata = 32'd0;
        rst_n = 1'b1;
        ic_req = 1'b1; ic_addr = 32'h1FC0_0000; ic_line = 1'b0; arready = 1'b1;
        tick();
        addr_phase("t5 post", 1'b0, 32'h1FC0_0000, 8'd0);
        beat("t5 post beat", 1'b0, 4'd0, 1'b1, 32'hFACE_0001);

        // Icache withdraws in IDLE while dcache requests: dcache must win
        dc_req = 1'b1; dc_addr = 32'h3000_0008; dc_line = 1'b0; arready = 1'b1;
        tick();
        addr_phase("t6 first", 1'b1, 32'h3000_0008, 8'd0);
        ic_req = 1'b1; ic_addr = 32'h4000_0000; ic_line = 1'b1;
        beat("t6 first beat", 1'b1, 4'd0, 1'b1, 32'h6666_0000);
        ic_req = 1'b0;
        dc_req = 1'b1; dc_addr = 32'h3000_0010; dc_line = 1'b0; arready = 1'b1;
        tick();
        addr_phase("t6 second", 1'b1, 32'h3000_0010, 8'd0);
        beat("t6 second beat", 1'b1, 4'd0, 1'b1, 32'h6666_0001);
        #1;
        chk("t6 no ic issue", 32'(arvalid), 32'd0);
        tick();
        #1;
        chk("t6 still idle", 32'({arvalid, ic_gnt, ic_valid}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
